// File: rtl/id_operand_hold_if.sv
// Operand-hold bus: forwarding/regfile/snoop inputs and resolved operands out.
// Falls back to a 6-bit stall bus when the pipeline defines are not loaded.
`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

interface id_operand_hold_if;
    logic             flush;
    logic [`StallBus] stall;
    logic [4:0]       rs_rf_raddr;
    logic [4:0]       rt_rf_raddr;
    logic [31:0]      rs_rf_rdata;
    logic [31:0]      rt_rf_rdata;
    logic             sel_rs_forward_r;
    logic             sel_rt_forward_r;
    logic [31:0]      rs_forward_data_r;
    logic [31:0]      rt_forward_data_r;
    logic             mem_we;
    logic [4:0]       mem_waddr;
    logic [31:0]      mem_wdata;
    logic             wb_we;
    logic [4:0]       wb_waddr;
    logic [31:0]      wb_wdata;
    logic [31:0]      rs_data;
    logic [31:0]      rt_data;
    logic             hold_active;
    logic [7:0]       hold_cycles;

    modport master (
        output flush, stall, rs_rf_raddr, rt_rf_raddr, rs_rf_rdata, rt_rf_rdata,
               sel_rs_forward_r, sel_rt_forward_r, rs_forward_data_r, rt_forward_data_r,
               mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata,
        input  rs_data, rt_data, hold_active, hold_cycles
    );

    modport slave (
        input  flush, stall, rs_rf_raddr, rt_rf_raddr, rs_rf_rdata, rt_rf_rdata,
               sel_rs_forward_r, sel_rt_forward_r, rs_forward_data_r, rt_forward_data_r,
               mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata,
        output rs_data, rt_data, hold_active, hold_cycles
    );
endinterface

// File: rtl/id_operand_hold.sv
// ID-stage operand hold: latches resolved rs/rt while ID stalls and snoops MEM/WB writes.
// Optional stall-cycle counter enabled by defining OPERAND_HOLD_STATS_EN.
module id_operand_hold (
    input  logic              clk,
    input  logic              rst,
    id_operand_hold_if.slave  bus
);
    // state   | meaning
    // ST_RUN  | operands come straight from forwarding/regfile (live)
    // ST_HOLD | ID stalled; operands come from hold regs refreshed by snoop
    typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t      r_state;
    logic        r_hold_active;
    logic [31:0] r_hold_rs;
    logic [31:0] r_hold_rt;

    logic        w_stall_id;
    logic        w_unused_stall;
    logic [31:0] w_live_rs;
    logic [31:0] w_live_rt;
    logic [31:0] w_held_rs;
    logic [31:0] w_held_rt;

    assign w_stall_id     = (bus.stall[2] == `Stop);
    assign w_unused_stall = ^bus.stall;

    always_comb begin
        w_live_rs = bus.rs_rf_rdata;
        if (bus.rs_rf_raddr == 5'd0)
            w_live_rs = 32'd0;
        else if (bus.sel_rs_forward_r)
            w_live_rs = bus.rs_forward_data_r;
        else if (bus.wb_we && (bus.wb_waddr == bus.rs_rf_raddr))
            w_live_rs = bus.wb_wdata;

        w_live_rt = bus.rt_rf_rdata;
        if (bus.rt_rf_raddr == 5'd0)
            w_live_rt = 32'd0;
        else if (bus.sel_rt_forward_r)
            w_live_rt = bus.rt_forward_data_r;
        else if (bus.wb_we && (bus.wb_waddr == bus.rt_rf_raddr))
            w_live_rt = bus.wb_wdata;
    end

    // MEM is the younger producer, so it beats WB on an address tie
    always_comb begin
        w_held_rs = r_hold_rs;
        if (bus.rs_rf_raddr == 5'd0)
            w_held_rs = 32'd0;
        else if (bus.mem_we && (bus.mem_waddr == bus.rs_rf_raddr))
            w_held_rs = bus.mem_wdata;
        else if (bus.wb_we && (bus.wb_waddr == bus.rs_rf_raddr))
            w_held_rs = bus.wb_wdata;

        w_held_rt = r_hold_rt;
        if (bus.rt_rf_raddr == 5'd0)
            w_held_rt = 32'd0;
        else if (bus.mem_we && (bus.mem_waddr == bus.rt_rf_raddr))
            w_held_rt = bus.mem_wdata;
        else if (bus.wb_we && (bus.wb_waddr == bus.rt_rf_raddr))
            w_held_rt = bus.wb_wdata;
    end

    assign bus.rs_data     = (r_state == ST_HOLD) ? w_held_rs : w_live_rs;
    assign bus.rt_data     = (r_state == ST_HOLD) ? w_held_rt : w_live_rt;
    assign bus.hold_active = r_hold_active;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_state       <= ST_RUN;
            r_hold_active <= 1'b0;
            r_hold_rs     <= 32'd0;
            r_hold_rt     <= 32'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_stall_id) begin
                        r_state       <= ST_HOLD;
                        r_hold_active <= 1'b1;
                        r_hold_rs     <= w_live_rs;
                        r_hold_rt     <= w_live_rt;
                    end
                end
                ST_HOLD: begin
                    if (w_stall_id) begin
                        r_hold_rs <= w_held_rs;
                        r_hold_rt <= w_held_rt;
                    end else begin
                        r_state       <= ST_RUN;
                        r_hold_active <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= ST_RUN;
                    r_hold_active <= 1'b0;
                end
            endcase
        end
    end

`ifdef OPERAND_HOLD_STATS_EN
    logic [7:0] r_hold_cycles;

    // saturating; deliberately kept across release so software can read it later
    always_ff @(posedge clk) begin
        if (rst || bus.flush)
            r_hold_cycles <= 8'd0;
        else if ((r_state == ST_HOLD) && (r_hold_cycles != 8'hFF))
            r_hold_cycles <= r_hold_cycles + 8'd1;
    end

    assign bus.hold_cycles = r_hold_cycles;
`else
    assign bus.hold_cycles = 8'h00;
`endif

endmodule

// File: tb/tb_id_operand_hold.sv
// Bench for id_operand_hold: per-cycle model comparison plus directed literal checks.
module tb_id_operand_hold;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    id_operand_hold_if u_if ();

    id_operand_hold dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: while stalled the operand delivered to EX must be remembered, and any
    // write to that register by a later-retiring producer replaces it.
    bit          m_valid = 1'b0;
    bit          m_holding = 1'b0;
    logic [31:0] m_val [2];
    int          m_cnt = 0;

    function automatic logic [31:0] model_out(input int op);
        logic [4:0]  ra;
        logic [31:0] rf;
        logic [31:0] fwd;
        logic        sel;
        ra  = (op == 0) ? u_if.rs_rf_raddr : u_if.rt_rf_raddr;
        rf  = (op == 0) ? u_if.rs_rf_rdata : u_if.rt_rf_rdata;
        fwd = (op == 0) ? u_if.rs_forward_data_r : u_if.rt_forward_data_r;
        sel = (op == 0) ? u_if.sel_rs_forward_r : u_if.sel_rt_forward_r;
        if (ra == 0) return 32'd0;
        if (m_holding) begin
            if (u_if.mem_we && u_if.mem_waddr == ra) return u_if.mem_wdata;
            if (u_if.wb_we && u_if.wb_waddr == ra) return u_if.wb_wdata;
            return m_val[op];
        end
        if (sel) return fwd;
        if (u_if.wb_we && u_if.wb_waddr == ra) return u_if.wb_wdata;
        return rf;
    endfunction

    always @(negedge clk) begin
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [7:0]  e_cnt;
        e_rs = model_out(0);
        e_rt = model_out(1);
`ifdef OPERAND_HOLD_STATS_EN
        e_cnt = 8'(m_cnt);
`else
        e_cnt = 8'h00;
`endif
        if (m_valid && !rst) begin
            chk("model rs_data", u_if.rs_data, e_rs);
            chk("model rt_data", u_if.rt_data, e_rt);
            chk("model hold_active", {31'd0, u_if.hold_active}, {31'd0, m_holding});
            chk("model hold_cycles", {24'd0, u_if.hold_cycles}, {24'd0, e_cnt});
        end
        if (rst || u_if.flush) begin
            m_holding = 1'b0;
            m_val[0]  = 32'd0;
            m_val[1]  = 32'd0;
            m_cnt     = 0;
            m_valid   = 1'b1;
        end else begin
            if (m_holding && m_cnt < 255) m_cnt++;
            if (u_if.stall[2]) begin
                m_val[0] = e_rs;
                m_val[1] = e_rt;
            end
            m_holding = u_if.stall[2];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_if.flush = 1'b0;
        u_if.stall = '0;
        u_if.rs_rf_raddr = 5'd0;
        u_if.rt_rf_raddr = 5'd0;
        u_if.rs_rf_rdata = 32'd0;
        u_if.rt_rf_rdata = 32'd0;
        u_if.sel_rs_forward_r = 1'b0;
        u_if.sel_rt_forward_r = 1'b0;
        u_if.rs_forward_data_r = 32'd0;
        u_if.rt_forward_data_r = 32'd0;
        u_if.mem_we = 1'b0;
        u_if.mem_waddr = 5'd0;
        u_if.mem_wdata = 32'd0;
        u_if.wb_we = 1'b0;
        u_if.wb_waddr = 5'd0;
        u_if.wb_wdata = 32'd0;
    endtask

    task automatic set_stall(input logic s);
        u_if.stall = '0;
        u_if.stall[2] = s;
    endtask

    initial begin
        idle_inputs();
        u_if.rs_rf_raddr = 5'd3;
        u_if.rs_rf_rdata = 32'h0000_CAFE;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("reset hold_active", {31'd0, u_if.hold_active}, 32'd0);
        chk("reset hold_cycles", {24'd0, u_if.hold_cycles}, 32'd0);
        chk("reset rs_data", u_if.rs_data, 32'h0000_CAFE);

        // load-use: forwarded value captured, MEM snoop updates on release
        cyc();
        u_if.rs_rf_raddr = 5'd5;
        u_if.rs_rf_rdata = 32'd0;
        u_if.sel_rs_forward_r = 1'b1;
        u_if.rs_forward_data_r = 32'h11;
        set_stall(1'b1);
        #1;
        chk("loaduse run rs_data", u_if.rs_data, 32'h11);
        chk("loaduse run hold_active", {31'd0, u_if.hold_active}, 32'd0);
        cyc();
        u_if.sel_rs_forward_r = 1'b0;
        u_if.rs_forward_data_r = 32'd0;
        u_if.mem_we = 1'b1;
        u_if.mem_waddr = 5'd5;
        u_if.mem_wdata = 32'h0000_AABB;
        set_stall(1'b0);
        #1;
        chk("loaduse release rs_data", u_if.rs_data, 32'h0000_AABB);
        chk("loaduse release hold_active", {31'd0, u_if.hold_active}, 32'd1);
        cyc();
        u_if.mem_we = 1'b0;
        u_if.rs_rf_rdata = 32'h0000_AABB;
        #1;
        chk("loaduse after hold_active", {31'd0, u_if.hold_active}, 32'd0);

        // WB retires the producer mid-stall while regfile read data is stale
        cyc();
        idle_inputs();
        u_if.rt_rf_raddr = 5'd7;
        set_stall(1'b1);
        cyc();
        u_if.wb_we = 1'b1;
        u_if.wb_waddr = 5'd7;
        u_if.wb_wdata = 32'h0000_1234;
        #1;
        chk("wb snoop cycle2 rt_data", u_if.rt_data, 32'h0000_1234);
        cyc();
        u_if.wb_we = 1'b0;
        #1;
        chk("wb snoop cycle3 rt_data", u_if.rt_data, 32'h0000_1234);
        cyc();
        set_stall(1'b0);
        #1;
        chk("wb snoop release rt_data", u_if.rt_data, 32'h0000_1234);

        // $0 never takes forwarded or snooped data
        cyc();
        idle_inputs();
        u_if.rs_rf_rdata = 32'h5;
        u_if.sel_rs_forward_r = 1'b1;
        u_if.rs_forward_data_r = 32'hFFFF_FFFF;
        u_if.mem_we = 1'b1;
        u_if.mem_wdata = 32'h0000_DEAD;
        set_stall(1'b1);
        #1;
        chk("zero reg run rs_data", u_if.rs_data, 32'd0);
        cyc();
        #1;
        chk("zero reg hold rs_data", u_if.rs_data, 32'd0);
        cyc();
        set_stall(1'b0);

        // both snoop ports hit the same register: MEM wins
        cyc();
        idle_inputs();
        u_if.rs_rf_raddr = 5'd9;
        u_if.rs_rf_rdata = 32'h77;
        set_stall(1'b1);
        cyc();
        u_if.mem_we = 1'b1;
        u_if.mem_waddr = 5'd9;
        u_if.mem_wdata = 32'h1;
        u_if.wb_we = 1'b1;
        u_if.wb_waddr = 5'd9;
        u_if.wb_wdata = 32'h2;
        #1;
        chk("dual snoop rs_data", u_if.rs_data, 32'h1);
        cyc();
        u_if.mem_we = 1'b0;
        u_if.wb_we = 1'b0;
        #1;
        chk("dual snoop retained rs_data", u_if.rs_data, 32'h1);
        cyc();
        set_stall(1'b0);

        // flush while holding: outputs still held this cycle, RUN afterwards
        cyc();
        u_if.rs_rf_rdata = 32'h55;
        set_stall(1'b1);
        cyc();
        u_if.rs_rf_rdata = 32'h66;
        u_if.flush = 1'b1;
        #1;
        chk("flush cycle rs_data", u_if.rs_data, 32'h55);
        chk("flush cycle hold_active", {31'd0, u_if.hold_active}, 32'd1);
        cyc();
        u_if.flush = 1'b0;
        set_stall(1'b0);
        #1;
        chk("post flush hold_active", {31'd0, u_if.hold_active}, 32'd0);
        chk("post flush hold_cycles", {24'd0, u_if.hold_cycles}, 32'd0);
        chk("post flush rs_data", u_if.rs_data, 32'h66);

        // long stall saturates the counter
        set_stall(1'b1);
        repeat (300) cyc();
        set_stall(1'b0);
        #1;
`ifdef OPERAND_HOLD_STATS_EN
        chk("long stall hold_cycles", {24'd0, u_if.hold_cycles}, 32'd255);
`else
        chk("long stall hold_cycles", {24'd0, u_if.hold_cycles}, 32'd0);
`endif
        cyc();
        #1;
`ifdef OPERAND_HOLD_STATS_EN
        chk("run keeps hold_cycles", {24'd0, u_if.hold_cycles}, 32'd255);
`else
        chk("run keeps hold_cycles", {24'd0, u_if.hold_cycles}, 32'd0);
`endif
        u_if.flush = 1'b1;
        cyc();
        u_if.flush = 1'b0;
        #1;
        chk("flush clears hold_cycles", {24'd0, u_if.hold_cycles}, 32'd0);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/id_operand_hold.md
# id_operand_hold

Per-operand hold and snoop stage at the ID end of the forwarding path: consumes the forwarding unit's registered select/data pair together with register-file read data and delivers the final rs/rt operands to EX. While ID is stalled (load-use or downstream stall), the forwarding registers are zeroed and the producer instruction keeps advancing. The block therefore latches the resolved operands and keeps them current by snooping the MEM-output and WB write ports until ID releases. Sits between the register file/forwarding unit and the ID→EX pipeline register.

## Interface
Parameters:
- none (StallBus width from lib/defines.vh; stall[2] = ID, `Stop`=1, `NoStop`=0)

Ports:
- clk  in  1  clock
- rst  in  1  reset; rst synchronous, active-high; clock clk
- flush  in  1  pipeline flush, synchronous
- stall  in  `StallBus`  pipeline stall bus; only stall[2] used
- rs_rf_raddr, rt_rf_raddr  in  5 each  ID source register numbers
- rs_rf_rdata, rt_rf_rdata  in  32 each  register-file read data
- sel_rs_forward_r, sel_rt_forward_r  in  1 each  registered forward select
- rs_forward_data_r, rt_forward_data_r  in  32 each  registered forward data
- mem_we, mem_waddr, mem_wdata  in  1/5/32  MEM→WB result (younger producer)
- wb_we, wb_waddr, wb_wdata  in  1/5/32  WB regfile write port (older producer)
- rs_data, rt_data  out  32 each  resolved operands to EX
- hold_active  out  1  registered; 1 while state = HOLD
- hold_cycles  out  8  stall-cycle counter (see Configuration)

## Operation
- Live value per operand X (rs/rt), priority high→low: raddr==0 → 0; sel_X_forward_r → X_forward_data_r; wb_we && wb_waddr==raddr → wb_wdata; else X_rf_rdata.
- Held value per operand: raddr==0 → 0; mem_we && mem_waddr==raddr → mem_wdata; wb_we && wb_waddr==raddr → wb_wdata; else hold_X register.
- FSM, two states, reset/flush → RUN:
  - RUN, stall[2]==NoStop: output live; stay RUN.
  - RUN, stall[2]==Stop: output live; hold_X ← live value; → HOLD.
  - HOLD, stall[2]==Stop: output held; hold_X ← held value; stay HOLD.
  - HOLD, stall[2]==NoStop: output held; → RUN (release cycle; EX captures held value).
- flush in any state: → RUN, hold_rs/hold_rt ← 0, counter cleared; same-cycle outputs still follow the current-state mux.
- raddr changing while in HOLD is illegal (ID register frozen); not checked.
- Both snoop ports matching same address: mem wins (younger).

## Timing
- rs_data/rt_data combinational from inputs and state; zero latency.
- State, hold_X, hold_active, hold_cycles update on posedge clk.
- Reset values: state RUN, hold_rs=hold_rt=0, hold_active=0, hold_cycles=0; rs_data/rt_data = live mux of inputs.
- rst overrides flush; flush overrides stall.
- Single-cycle stall: one HOLD cycle (output held, release), then RUN.
- Snoop written in cycle t is visible on the output in the same cycle t and retained from t+1.

## Configuration
- OPERAND_HOLD_STATS_EN defined: hold_cycles increments each posedge while state==HOLD, saturates at 255, clears on rst/flush; holds value in RUN (not cleared on release).
- Undefined: hold_cycles tied to 8'h00, no counter logic.

## Test plan
- Reset: rst=1 two cycles → hold_active=0, hold_cycles=0, rs_data=rs_rf_rdata with sel=0.
- Load-use: rs=$5, RUN, stall[2]=Stop, sel_rs=1 fwd=0x11 → rs_data=0x11; next cycle sel=0, mem_we=1 waddr=5 wdata=0xAABB, stall released → rs_data=0xAABB, hold_active was 1, back to RUN.
- Producer retires during multi-cycle stall: 3-cycle stall, wb writes $7=0x1234 in cycle 2, rf_rdata stale 0 → rt_data=0x1234 in cycles 2–3 and release.
- $0 protection: raddr=0, sel=1 fwd=0xFFFF_FFFF, mem_we waddr=0 → rs_data=0 in RUN and HOLD.
- Dual snoop conflict: HOLD, mem and wb both write $9 (0x1 / 0x2) → rs_data=0x1.
- Flush mid-HOLD: flush=1 in HOLD → next cycle hold_active=0, hold_cycles=0, hold regs 0; with OPERAND_HOLD_STATS_EN, 300-cycle stall → hold_cycles=255.
